// File: rtl/button_event_pkg.sv
// Shared I/O-path constants: state encoding for the button event block.
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_e;

  function automatic logic state_is_held(input btn_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/button_event.sv
// Converts a debounced button level into single-cycle press, release,
// long-press and auto-repeat pulses plus a held level.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  btn_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;
  logic                 repeat_q, repeat_d;

  // Next-state, hold counter and pulse decode; release takes priority over a count match.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in) begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
          press_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!in) begin
          state_d   = ST_IDLE;
          cnt_d     = CNT_ZERO;
          release_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          cnt_d   = CNT_ZERO;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (!in) begin
          state_d   = ST_IDLE;
          cnt_d     = CNT_ZERO;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = CNT_ZERO;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = state_is_held(state_q);

endmodule
